// File: rtl/bp_update_queue.sv
// Commit-side branch predictor update queue: buffers resolved branch
// outcomes in order and drains them to the predictor, with debug counters.
module bp_update_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       commit_en,
    input  logic [PC_WIDTH-1:0]        commit_pc,
    input  logic                       commit_taken,
    input  logic                       commit_pred,
    output logic                       full,
    output logic                       upd_valid,
    output logic [PC_WIDTH-1:0]        upd_pc,
    output logic                       upd_taken,
    input  logic                       upd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                branch_cnt,
    output logic [31:0]                mispredict_cnt,
    output logic [15:0]                drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_WIDTH:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              push;
    logic              pop;
    logic              drop;
    logic [PC_WIDTH:0] head_entry;

    assign full      = (count == FULL_CNT);
    assign upd_valid = (count != '0);
    assign push      = commit_en & rdy_in & ~full;
    assign pop       = upd_valid & upd_ready & rdy_in;
    assign drop      = commit_en & rdy_in & full;

    // Head outputs are forced to zero while empty so reset shows a clean bus
    // even though storage itself is never cleared.
    assign head_entry = mem[head];
    assign upd_pc     = upd_valid ? head_entry[PC_WIDTH:1] : '0;
    assign upd_taken  = upd_valid & head_entry[0];

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[tail] <= {commit_pc, commit_taken};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            drop_cnt       <= '0;
        end else begin
            if (push) begin
                branch_cnt <= branch_cnt + 32'd1;
                if (commit_taken != commit_pred) begin
                    mispredict_cnt <= mispredict_cnt + 32'd1;
                end
            end
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/bp_update_queue.md
# bp_update_queue

Commit-side writer for the branch predictor's update interface. It accepts resolved conditional-branch outcomes from the RoB at commit and buffers them in a small in-order FIFO. It drains them to the predictor with a valid/ready handshake, so predictor table writes never stall commit. It also keeps running branch and misprediction counts for debug and performance readout.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- PC_WIDTH, 32, width of the branch PC carried per entry
- clk_in  in  1  clock; all state changes on the rising edge
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global ready; low means pause, with no push, no pop and counters held
- commit_en  in  1  RoB commits a conditional branch this cycle
- commit_pc  in  PC_WIDTH  PC of the committing branch
- commit_taken  in  1  resolved direction (1 = taken)
- commit_pred  in  1  direction predicted at fetch (1 = taken)
- full  out  1  FIFO holds DEPTH entries; RoB must not assert commit_en while high
- upd_valid  out  1  head entry available to predictor
- upd_pc  out  PC_WIDTH  head entry PC
- upd_taken  out  1  head entry resolved direction
- upd_ready  in  1  predictor accepts head entry this cycle
- count  out  $clog2(DEPTH)+1  current occupancy
- branch_cnt  out  32  accepted branch commits since reset
- mispredict_cnt  out  32  accepted commits with commit_taken != commit_pred
- drop_cnt  out  16  commit_en pulses ignored because full

## Operation
- Storage: DEPTH-entry circular buffer of {pc, taken}; head pointer and tail pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH; count is held separately.
- Push: push = commit_en & rdy_in & ~full. On a push, the entry is written at tail, tail increments, and branch_cnt increments.
- If the pushed entry has commit_taken != commit_pred, mispredict_cnt also increments.
- Pop: pop = upd_valid & upd_ready & rdy_in. On a pop, head increments.
- Count update: count += push - pop. Simultaneous push and pop leaves count unchanged, and both pointers advance.
- Full rule: full = (count == DEPTH), evaluated from registered count.
  - A commit_en while full is dropped even if a pop happens in the same cycle; there is no combinational path from upd_ready to acceptance.
  - A dropped commit increments drop_cnt (saturating at 16'hFFFF). branch_cnt and mispredict_cnt do not change.
- Empty: upd_valid = (count != 0). upd_pc and upd_taken show the head entry; their value is don't-care when upd_valid is 0.
- Ordering: entries leave in exact commit order; there is no reordering, coalescing or bypass.
- Counter widths: branch_cnt and mispredict_cnt wrap modulo 2^32.
- No flush input: committed outcomes are architecturally final and are always delivered.
- rdy_in low:
  - All registers hold.
  - upd_valid and the head outputs stay stable.
  - A handshake in that cycle does not count as a transfer; the predictor must not consume the entry.

## Timing
- Reset (asynchronous, takes effect immediately): head = tail = 0, count = 0, full = 0, upd_valid = 0, upd_pc = 0, upd_taken = 0, branch_cnt = mispredict_cnt = drop_cnt = 0. Storage contents are don't-care.
- Reset asserted mid-operation discards all buffered entries; after reset deasserts, the first edge with rdy_in high may accept a push.
- Push-to-visible latency: an entry pushed on edge N gives upd_valid = 1 with that entry at the head in the cycle after edge N. There is no same-cycle bypass.
- Pop takes effect on the edge where pop is true; the next entry, if any, appears at the head in the following cycle.
- full, count and the statistics counters reflect all pushes and pops up to and including the last edge.
- Maximum throughput is one push and one pop per cycle.

## Test plan
- Reset, then push pc 0x100 (taken=1, pred=1) with upd_ready=0 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=1, count=1, branch_cnt=1, mispredict_cnt=0.
- With upd_ready=0 and DEPTH=4, push 0x10, 0x20, 0x30, 0x40, then a fifth push of 0x50 -> full=1, count=4, drop_cnt=1, branch_cnt=4. Raising upd_ready then drains 0x10, 0x20, 0x30, 0x40 in order and upd_valid falls after the fourth pop.
- Run continuous push and pop for 10 cycles with count=2 -> count stays 2, pointers wrap past DEPTH-1, and the output order matches the input order.
- Push 3 entries with taken/pred of (1,0), (0,0), (0,1) -> branch_cnt=3, mispredict_cnt=2.
- Hold rdy_in=0 for 3 cycles while commit_en=1 and upd_ready=1 with count=1 -> count, head outputs and all counters are unchanged; activity resumes on the first edge with rdy_in high.
- Assert rst_in between clock edges with count=3 -> immediately upd_valid=0, count=0, full=0 and all counters 0.
